// File: rtl/isa_loop_sequencer_if.sv
// Host/core bus of the loop sequencer: program load, run control,
// command strobe and status.
interface isa_loop_sequencer_if #(
    parameter int LOG_COMMAND = 8,
    parameter int PROG_LOG    = 5
) ();
    logic                   start;
    logic                   abort;
    logic [PROG_LOG-1:0]    prog_addr;
    logic [63:0]            prog_data;
    logic                   prog_we;
    logic                   done_ins;
    logic [LOG_COMMAND-1:0] command_out;
    logic                   command_we;
    logic                   busy;
    logic                   done_all;
    logic                   error;
    logic [PROG_LOG-1:0]    pc;
    logic [30:0]            cycle_count;

    modport master (
        output start, abort, prog_addr, prog_data,
        output prog_we, done_ins,
        input  command_out, command_we, busy,
        input  done_all, error, pc, cycle_count
    );

    modport slave (
        input  start, abort, prog_addr, prog_data,
        input  prog_we, done_ins,
        output command_out, command_we, busy,
        output done_all, error, pc, cycle_count
    );
endinterface

// File: rtl/isa_loop_sequencer.sv
// Program sequencer: fetches 64-bit instructions, issues commands to a
// compute core and runs a single non-nesting hardware loop.
module isa_loop_sequencer #(
    parameter int LOG_COMMAND = 8,
    parameter int PROG_LOG    = 5
) (
    input  logic                clk,
    input  logic                rst,
    isa_loop_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << PROG_LOG;
    localparam logic [PROG_LOG-1:0] PC_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT, DONE, ERROR
    } state_t;

    state_t state, state_n;

    logic [63:0] mem [DEPTH];
    logic [1:0]             op;
    logic [LOG_COMMAND-1:0] op_cmd;
    logic [PROG_LOG-1:0]    op_tgt;
    logic [7:0]             op_cnt;

    logic [PROG_LOG-1:0]    pc, pc_n;
    logic                   loop_act, loop_act_n;
    logic [7:0]             loop_cnt, loop_cnt_n;
    logic [LOG_COMMAND-1:0] cmd, cmd_n;
    logic [30:0]            cyc, cyc_n;
    logic                   start_q, armed, rise, busy, adv;

    assign busy = !(state inside {IDLE, DONE, ERROR});
    // armed blocks a start level held high through reset
    assign rise = bus.start & ~start_q & armed;

    always_ff @(posedge clk) begin
        if (bus.prog_we && !busy)
            mem[bus.prog_addr] <= bus.prog_data;
        op     <= mem[pc][63:62];
        op_cmd <= mem[pc][LOG_COMMAND-1:0];
        op_tgt <= mem[pc][8+PROG_LOG-1:8];
        op_cnt <= mem[pc][23:16];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= bus.start;
            if (!bus.start)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= '0;
            loop_act <= 1'b0;
            loop_cnt <= '0;
            cmd      <= '0;
            cyc      <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            loop_act <= loop_act_n;
            loop_cnt <= loop_cnt_n;
            cmd      <= cmd_n;
            cyc      <= cyc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        loop_act_n = loop_act;
        loop_cnt_n = loop_cnt;
        cmd_n      = cmd;
        cyc_n      = cyc;
        adv        = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            if (busy && cyc != '1)
                cyc_n = cyc + 31'd1;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (rise) begin
                        state_n    = FETCH;
                        pc_n       = '0;
                        loop_act_n = 1'b0;
                        loop_cnt_n = '0;
                        cyc_n      = '0;
                    end
                end
                FETCH: state_n = DECODE;
                DECODE: begin
                    unique case (op)
                        2'b00: begin
                            cmd_n   = op_cmd;
                            state_n = ISSUE;
                        end
                        2'b01: begin
                            state_n = FETCH;
                            if (!loop_act && op_cnt == 8'd0) begin
                                adv = 1'b1;
                            end else if (!loop_act) begin
                                loop_cnt_n = op_cnt - 8'd1;
                                loop_act_n = 1'b1;
                                pc_n       = op_tgt;
                            end else if (loop_cnt != 8'd0) begin
                                loop_cnt_n = loop_cnt - 8'd1;
                                pc_n       = op_tgt;
                            end else begin
                                loop_act_n = 1'b0;
                                adv        = 1'b1;
                            end
                        end
                        2'b10:   state_n = DONE;
                        default: state_n = ERROR;
                    endcase
                end
                ISSUE: state_n = WAIT;
                WAIT: adv = bus.done_ins;
                default: state_n = IDLE;
            endcase
            // stepping past the last slot ends the program
            if (adv) begin
                if (pc == PC_MAX) begin
                    state_n = DONE;
                end else begin
                    pc_n    = pc + 1'b1;
                    state_n = FETCH;
                end
            end
        end
    end

    assign bus.command_out = cmd;
    assign bus.command_we  = (state == ISSUE);
    assign bus.busy        = busy;
    assign bus.done_all    = (state == DONE);
    assign bus.error       = (state == ERROR);
    assign bus.pc          = pc;
    assign bus.cycle_count = cyc;
endmodule

// File: tb/tb_isa_loop_sequencer.sv
// Bench for isa_loop_sequencer: directed programs plus random programs
// checked against an instruction-level interpreter of the program.
module tb_isa_loop_sequencer;
    localparam int LC = 8;
    localparam int PL = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    isa_loop_sequencer_if #(.LOG_COMMAND(LC), .PROG_LOG(PL)) bus ();

    isa_loop_sequencer #(.LOG_COMMAND(LC), .PROG_LOG(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] prog [32];
    logic [7:0]  exp_cmds [$];
    logic [7:0]  got_cmds [$];
    int exp_end, exp_pc, exp_cyc, exp_wrap;
    int got_end, got_first;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ins(input logic [1:0] op,
                                        input logic [7:0] cnt,
                                        input logic [4:0] tgt,
                                        input logic [7:0] c);
        logic [63:0] w;
        w = '0;
        w[63:62] = op;
        w[23:16] = cnt;
        w[12:8]  = tgt;
        w[7:0]   = c;
        return w;
    endfunction

    task automatic load();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.prog_we   = 1'b1;
            bus.prog_addr = 5'(i);
            bus.prog_data = prog[i];
        end
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    // Interpreter: walks the program, counting the cycles each
    // instruction costs (EXEC: fetch+decode+issue+wait, others 2).
    task automatic ref_model(input int lat);
        int p, act, lc, steps;
        bit fin;
        p = 0; act = 0; lc = 0; steps = 0; fin = 0;
        exp_cmds.delete();
        exp_end = 0; exp_cyc = 0; exp_wrap = 0;
        while (!fin && steps < 5000) begin
            logic [63:0] w;
            bit nxt;
            int c, t;
            steps++;
            nxt = 0;
            w = prog[p];
            c = int'(w[23:16]);
            t = int'(w[12:8]);
            case (w[63:62])
                2'b00: begin
                    exp_cmds.push_back(w[7:0]);
                    exp_cyc += 3 + lat;
                    nxt = 1;
                end
                2'b01: begin
                    exp_cyc += 2;
                    if (act == 0 && c == 0) nxt = 1;
                    else if (act == 0) begin
                        lc = c - 1; act = 1; p = t;
                    end else if (lc > 0) begin
                        lc--; p = t;
                    end else begin
                        act = 0; nxt = 1;
                    end
                end
                2'b10: begin
                    exp_cyc += 2; fin = 1; exp_end = 1;
                end
                default: begin
                    exp_cyc += 2; fin = 1; exp_end = 2;
                end
            endcase
            if (nxt) begin
                if (p == 31) begin
                    fin = 1; exp_end = 1; exp_wrap = 1;
                end else begin
                    p++;
                end
            end
        end
        exp_pc = p;
    endtask

    task automatic run(input int lat, input int budget,
                       input int wr_at, input int rs_at);
        int pend;
        pend = 0;
        got_cmds.delete();
        got_first = -1;
        got_end = 0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            bus.done_ins = 1'b0;
            bus.prog_we  = 1'b0;
            if (i == 1) bus.start = 1'b0;
            if (i == rs_at) bus.start = 1'b1;
            if (i == rs_at + 1) bus.start = 1'b0;
            if (i == wr_at) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = 5'd31;
                bus.prog_data = ins(2'b10, 8'd0, 5'd0, 8'd0);
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) bus.done_ins = 1'b1;
            end
            if (bus.command_we) begin
                got_cmds.push_back(bus.command_out);
                if (got_first < 0) got_first = i;
                pend = lat;
            end
            if (bus.done_all || bus.error) begin
                got_end = bus.done_all ? 1 : 2;
                break;
            end
        end
        bus.done_ins = 1'b0;
        bus.prog_we  = 1'b0;
    endtask

    task automatic check_run(input string t);
        chk({t, "_end"}, 64'(got_end), 64'(exp_end));
        chk({t, "_busy"}, 64'(bus.busy), 64'd0);
        chk({t, "_cyc"}, 64'(bus.cycle_count), 64'(exp_cyc));
        chk({t, "_ncmd"}, 64'(got_cmds.size()), 64'(exp_cmds.size()));
        for (int i = 0; i < got_cmds.size() && i < exp_cmds.size(); i++)
            chk({t, "_cmd"}, 64'(got_cmds[i]), 64'(exp_cmds[i]));
        if (exp_wrap == 0)
            chk({t, "_pc"}, 64'(bus.pc), 64'(exp_pc));
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) prog[i] = ins(2'b10, 8'd0, 5'd0, 8'd0);
    endtask

    task automatic reach_wait(input string t);
        bit seen;
        seen = 0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (bus.command_we) seen = 1;
        end
        chk({t, "_strobe"}, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, ls;
        rst = 1'b0;
        bus.start = 0; bus.abort = 0; bus.prog_we = 0;
        bus.prog_addr = '0; bus.prog_data = '0; bus.done_ins = 0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pc", 64'(bus.pc), 64'd0);
        chk("rst_we", 64'(bus.command_we), 64'd0);
        chk("rst_cmd", 64'(bus.command_out), 64'd0);
        chk("rst_done", 64'(bus.done_all), 64'd0);
        chk("rst_err", 64'(bus.error), 64'd0);
        chk("rst_cyc", 64'(bus.cycle_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        fill_halt();
        prog[0] = ins(2'b00, 8'd0, 5'd0, 8'h11);
        prog[1] = ins(2'b00, 8'd0, 5'd0, 8'h22);
        load();
        ref_model(5);
        run(5, 200, -1, -1);
        check_run("t040");
        chk("t040_first_we", 64'(got_first), 64'd3);

        fill_halt();
        prog[0] = ins(2'b00, 8'd0, 5'd0, 8'h05);
        prog[1] = ins(2'b01, 8'd3, 5'd0, 8'd0);
        load();
        ref_model(2);
        run(2, 300, -1, -1);
        check_run("t041");
        chk("t041_pc2", 64'(bus.pc), 64'd2);

        fill_halt();
        prog[0] = ins(2'b01, 8'd0, 5'd0, 8'd0);
        load();
        ref_model(1);
        run(1, 100, -1, -1);
        check_run("t042");

        fill_halt();
        prog[0] = ins(2'b00, 8'd0, 5'd0, 8'h07);
        prog[1] = ins(2'b11, 8'd0, 5'd0, 8'd0);
        load();
        ref_model(2);
        run(2, 100, -1, -1);
        check_run("t043");
        chk("t043_err", 64'(bus.error), 64'd1);

        for (int i = 0; i < 32; i++)
            prog[i] = ins(2'b00, 8'd0, 5'd0, 8'(i + 8'h40));
        load();
        ref_model(1);
        run(1, 400, 20, 40);
        check_run("t045");
        chk("t045_cyc128", 64'(bus.cycle_count), 64'd128);

        fill_halt();
        prog[0] = ins(2'b00, 8'd0, 5'd0, 8'h11);
        prog[1] = ins(2'b00, 8'd0, 5'd0, 8'h22);
        load();
        reach_wait("t044");
        bus.abort = 1'b1;
        bus.done_ins = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.done_ins = 1'b0;
        chk("t044_busy", 64'(bus.busy), 64'd0);
        chk("t044_pc", 64'(bus.pc), 64'd0);
        chk("t044_we", 64'(bus.command_we), 64'd0);
        chk("t044_done", 64'(bus.done_all), 64'd0);
        chk("t044_err", 64'(bus.error), 64'd0);
        chk("t044_cyc", 64'(bus.cycle_count), 64'd3);
        bus.done_ins = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            bus.done_ins = 1'b0;
            if (bus.command_we) n++;
        end
        chk("t044_nostrobe", 64'(n), 64'd0);
        chk("t044_idle_pc", 64'(bus.pc), 64'd0);

        reach_wait("rstw");
        #2;
        rst = 1'b0;
        bus.start = 1'b1;
        #1;
        chk("rstw_busy", 64'(bus.busy), 64'd0);
        chk("rstw_we", 64'(bus.command_we), 64'd0);
        chk("rstw_pc", 64'(bus.pc), 64'd0);
        chk("rstw_cyc", 64'(bus.cycle_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.command_we || bus.busy) n++;
        end
        chk("held_start_norun", 64'(n), 64'd0);
        bus.start = 1'b0;

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(3, 10);
            lat = $urandom_range(1, 4);
            fill_halt();
            for (int i = 0; i < n - 1; i++) begin
                prog[i] = {$urandom, $urandom};
                prog[i][63:62] = 2'b00;
            end
            if ($urandom_range(0, 1) == 1) begin
                ls = $urandom_range(1, n - 2);
                prog[ls] = {$urandom, $urandom};
                prog[ls][63:62] = 2'b01;
                prog[ls][12:8]  = 5'($urandom_range(0, ls));
                prog[ls][23:16] = 8'($urandom_range(0, 4));
            end
            prog[n-1] = {$urandom, $urandom};
            prog[n-1][63:62] = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
            load();
            ref_model(lat);
            run(lat, 600, -1, -1);
            check_run("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/isa_loop_sequencer.md
ISA_LOOP_SEQUENCER -- requirements
Module: isa_loop_sequencer

Interface
REQ-001 SHALL have parameter LOG_COMMAND, default 8, the command byte width issued to the compute core.
REQ-002 SHALL have parameter PROG_LOG, default 5, the log2 program depth (32 instruction slots).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a level from the host; the sequencer acts on its rising edge only.
REQ-006 SHALL have port abort, input, 1, a synchronous stop request.
REQ-007 SHALL have port prog_addr, input, PROG_LOG, the program write address.
REQ-008 SHALL have port prog_data, input, 64, the instruction word.
REQ-009 SHALL have port prog_we, input, 1, the program write strobe.
REQ-010 SHALL have port done_ins, input, 1, the core's instruction-complete pulse.
REQ-011 SHALL have port command_out, output, LOG_COMMAND, the command to the core.
REQ-012 SHALL have port command_we, output, 1, a one-cycle command strobe.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE, DONE or ERROR.
REQ-014 SHALL have port done_all, output, 1, indicating the program completed.
REQ-015 SHALL have port error, output, 1, indicating a reserved opcode was hit.
REQ-016 SHALL have port pc, output, PROG_LOG, the current program counter.
REQ-017 SHALL have port cycle_count, output, 31, the run-time cycle counter.

Function
REQ-018 SHALL hold a 2^PROG_LOG x 64 program store with synchronous read, written when prog_we=1 and the state is not busy; a write while busy SHALL be dropped.
REQ-019 SHALL decode instruction bits [63:62] as follows: 00 EXEC (command=[LOG_COMMAND-1:0]); 01 LOOP (target=[8+PROG_LOG-1:8], count=[23:16]); 10 HALT; 11 reserved.
REQ-020 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT, DONE and ERROR.
REQ-021 SHALL transition IDLE/DONE/ERROR -> FETCH on a start rising edge, with pc=0, loop state cleared, cycle_count=0, and done_all/error cleared.
REQ-022 SHALL, in FETCH, present pc to the store; DECODE SHALL follow unconditionally.
REQ-023 SHALL, in DECODE with an EXEC instruction, go to ISSUE with command_out latched.
REQ-024 SHALL, in DECODE with HALT, go to DONE.
REQ-025 SHALL, in DECODE with a reserved opcode, go to ERROR.
REQ-026 SHALL, in DECODE with LOOP, apply the loop rule and go to FETCH.
REQ-027 SHALL drive command_we=1 for exactly the single ISSUE cycle, then enter WAIT.
REQ-028 SHALL, in WAIT, on done_ins=1 set pc=pc+1 and go to FETCH; done_ins outside WAIT SHALL be ignored.
REQ-029 SHALL apply the LOOP rule with a single, non-nesting counter: if the loop is inactive and count=0, pc+1 (no-op); if inactive and count>0, set loop_cnt=count-1, mark active, pc=target; if active and loop_cnt>0, decrement and pc=target; if active and loop_cnt=0, clear active and pc+1. The body therefore runs count+1 times.
REQ-030 SHALL treat a pc increment from 2^PROG_LOG-1 (wrap) as an implicit HALT and go to DONE.
REQ-031 SHALL assert command_we exactly 3 cycles after the edge that samples the start rising edge.
REQ-032 SHALL increment cycle_count every cycle while busy, saturating at 2^31-1, and hold it in DONE/ERROR.
REQ-033 SHALL make abort=1 force IDLE from any state on the next edge, with command_we=0, done_all=0, error=0, and cycle_count held.
REQ-034 SHALL give abort priority over start and done_ins when they occur in the same cycle.
REQ-035 SHALL ignore a start rising edge while busy.
REQ-036 SHALL set done_all=1 in DONE and error=1 in ERROR, each held until the next start or abort.

Reset
REQ-037 SHALL, on rst=0, asynchronously force state=IDLE, pc=0, command_out=0, command_we=0, done_all=0, error=0, cycle_count=0, loop state cleared, and the start edge detector=0.
REQ-038 SHALL leave program store contents undefined after reset; a reset mid-WAIT SHALL abandon the instruction without a further command_we.
REQ-039 SHALL require a rising edge of start after rst deasserts; start held high through reset SHALL NOT launch a run.

Verification
REQ-040 SHALL cover: program {EXEC 0x11, EXEC 0x22, HALT}, done_ins 5 cycles after each strobe -> command_out 0x11 then 0x22, two command_we pulses, done_all=1, error=0.
REQ-041 SHALL cover: {EXEC 0x05, LOOP target=0 count=3, HALT} -> four 0x05 strobes, then done_all=1, pc=2.
REQ-042 SHALL cover: LOOP count=0 at slot 0, HALT at slot 1 -> zero strobes, done_all=1.
REQ-043 SHALL cover: reserved opcode 11 at slot 1 after EXEC 0x07 -> one strobe, then error=1, pc=1, busy=0.
REQ-044 SHALL cover: abort asserted in WAIT in the same cycle as done_ins -> IDLE next cycle, no further strobe, pc unchanged.
REQ-045 SHALL cover: 32 EXEC slots, no HALT, done_ins 1 cycle after each strobe -> 32 strobes, wrap to DONE, cycle_count=32*4=128 (+/-1 per the REQ-032 window).
